// File: rtl/joy_serial_reader_if.sv
// Pin bundle between joy_serial_reader and the external joystick shift chain.
// The slave modport is the reader; the master modport is the chain/host side.
interface joy_serial_reader_if #(
  parameter int NUM_PLAYERS = 2
);
  logic                        joy_data;
  logic                        osd_mask;
  logic                        joy_clk;
  logic                        joy_load;
  logic [NUM_PLAYERS*16-1:0]   joystick;
  logic                        frame_done;

  modport master (
    output joy_data, osd_mask,
    input  joy_clk, joy_load, joystick, frame_done
  );

  modport slave (
    input  joy_data, osd_mask,
    output joy_clk, joy_load, joystick, frame_done
  );
endinterface

// File: rtl/joy_serial_reader.sv
// Polls a parallel-load serial joystick chain and presents one atomic frame per player.
// Define JOY_SERIAL_DEBOUNCE_EN to accept a frame only when two consecutive raw frames match.
module joy_serial_reader #(
  parameter int NUM_PLAYERS     = 2,
  parameter int BITS_PER_PLAYER = 12,
  parameter int CLK_DIV         = 8,
  parameter int FRAME_GAP       = 1024
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  joy_serial_reader_if.slave bus
);

  localparam int TOTAL = NUM_PLAYERS * BITS_PER_PLAYER;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [15:0]      GAP_LAST = (FRAME_GAP == 0) ? 16'd0 : 16'(FRAME_GAP - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(TOTAL - 1);

  typedef enum logic [1:0] {ST_GAP, ST_LOAD, ST_SHIFT, ST_UPDATE} state_t;

  state_t                    state;
  logic [7:0]                div;
  logic                      tick;
  logic                      phase;
  logic [CNT_W-1:0]          bit_cnt;
  logic [15:0]               gap_cnt;
  logic [1:0]                sync;
  logic [TOTAL-1:0]          shreg;
  logic [TOTAL-1:0]          frame_q;
  logic                      clk_q;
  logic                      load_q;
  logic                      done_q;
  logic [NUM_PLAYERS*16-1:0] joy_map;
`ifdef JOY_SERIAL_DEBOUNCE_EN
  logic [TOTAL-1:0]          prev_q;
`endif

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) sync <= '1;
    else          sync <= {sync[0], bus.joy_data};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_LOAD;
      div     <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      shreg   <= '0;
      frame_q <= '0;
      clk_q   <= 1'b0;
      load_q  <= 1'b1;
      done_q  <= 1'b0;
`ifdef JOY_SERIAL_DEBOUNCE_EN
      prev_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      div    <= tick ? '0 : div + 8'd1;
      case (state)
        ST_LOAD: begin
          load_q <= 1'b0;
          clk_q  <= 1'b0;
          if (tick) begin
            state   <= ST_SHIFT;
            load_q  <= 1'b1;
            phase   <= 1'b0;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (!phase) begin
              // Shift in at the top so the first bit ends up at index 0.
              shreg <= TOTAL'({~sync[1], shreg} >> 1);
              clk_q <= 1'b1;
              phase <= 1'b1;
            end else begin
              clk_q <= 1'b0;
              phase <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                state  <= ST_UPDATE;
                done_q <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
        ST_UPDATE: begin
`ifdef JOY_SERIAL_DEBOUNCE_EN
          if (shreg == prev_q) frame_q <= shreg;
          prev_q <= shreg;
`else
          frame_q <= shreg;
`endif
          gap_cnt <= '0;
          if (FRAME_GAP == 0) begin
            state <= ST_LOAD;
            div   <= '0;
          end else begin
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_LOAD;
            div   <= '0;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  always_comb begin
    joy_map = '0;
    for (int unsigned p = 0; p < unsigned'(NUM_PLAYERS); p++)
      for (int unsigned b = 0; b < unsigned'(BITS_PER_PLAYER); b++)
        joy_map[p*16 + b] = frame_q[p*BITS_PER_PLAYER + b];
  end

  assign bus.joy_clk    = clk_q;
  assign bus.joy_load   = load_q;
  assign bus.frame_done = done_q;
  assign bus.joystick   = bus.osd_mask ? '0 : joy_map;

endmodule

// File: tb/tb_joy_serial_reader.sv
// Scoreboard bench for joy_serial_reader: a chain model feeds random frames, a monitor
// checks every cycle of joystick output and every frame_done against a frame-level model.
module tb_joy_serial_reader;
  localparam int NP    = 2;
  localparam int BP    = 12;
  localparam int CDIV  = 4;
  localparam int GAP   = 16;
  localparam int TOTAL = NP * BP;
  localparam int PERIOD     = CDIV * (1 + 2 * TOTAL) + 1 + GAP;
  localparam int FIRST_DONE = CDIV * (1 + 2 * TOTAL) + 1;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  joy_serial_reader_if #(.NUM_PLAYERS(NP)) bus ();

  joy_serial_reader #(
    .NUM_PLAYERS(NP), .BITS_PER_PLAYER(BP), .CLK_DIV(CDIV), .FRAME_GAP(GAP)
  ) dut (
    .clk_sys(clk), .reset_n(reset_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int last_done = 0;
  bit after_reset = 1'b0;

  logic [TOTAL-1:0] next_pat = '0;
  logic [TOTAL-1:0] cur_pat  = '0;
  logic [TOTAL-1:0] exp_q[$];
  logic [TOTAL-1:0] m_latched = '0;
  logic [TOTAL-1:0] m_prev = '0;
  int idx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Parallel-load shift chain: pressed buttons pull the line low.
  always @(negedge bus.joy_load) begin
    cur_pat = next_pat;
    exp_q.push_back(next_pat);
    idx = 0;
  end
  always @(posedge bus.joy_clk) idx = idx + 1;
  assign bus.joy_data = (idx < TOTAL) ? ~cur_pat[idx] : 1'b1;

  function automatic logic [NP*16-1:0] expand(input logic [TOTAL-1:0] raw);
    logic [NP*16-1:0] r = '0;
    for (int p = 0; p < NP; p++)
      for (int b = 0; b < BP; b++)
        r[p*16 + b] = raw[p*BP + b];
    return r;
  endfunction

  // Monitor: output must always match the model; each frame_done consumes one frame.
  always @(negedge clk) begin
    if (reset_n) begin
      logic [NP*16-1:0] want;
      logic [TOTAL-1:0] raw;
      int got, need;
      want = bus.osd_mask ? '0 : expand(m_latched);
      checks++;
      if (bus.joystick !== want) begin
        errors++;
        $display("FAIL joystick cyc=%0d got=%h want=%h", cyc, bus.joystick, want);
      end
      if (bus.frame_done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_pop cyc=%0d got=frame_done want=no_frame_pending", cyc);
        end else begin
          raw = exp_q.pop_front();
`ifdef JOY_SERIAL_DEBOUNCE_EN
          if (raw == m_prev) m_latched = raw;
          m_prev = raw;
`else
          m_latched = raw;
`endif
        end
        checks++;
        if (after_reset) begin got = cyc - rel_cyc + 1; need = FIRST_DONE; end
        else             begin got = cyc - last_done;   need = PERIOD;     end
        if (got != need) begin
          errors++;
          $display("FAIL frame_period cyc=%0d got=%0d want=%0d", cyc, got, need);
        end
        last_done = cyc;
        after_reset = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wait_frame();
    bit ok = 1'b0;
    for (int n = 0; n < 2 * PERIOD; n++) begin
      @(negedge clk);
      if (bus.frame_done) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout got=no_frame_done want=frame_done within %0d", 2 * PERIOD);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_joystick"},   64'(bus.joystick),   64'd0);
    check({tag, "_frame_done"}, 64'(bus.frame_done), 64'd0);
    check({tag, "_joy_clk"},    64'(bus.joy_clk),    64'd0);
    check({tag, "_joy_load"},   64'(bus.joy_load),   64'd1);
  endtask

  task automatic release_reset();
    @(posedge clk); #3;
    exp_q.delete();
    reset_n = 1'b1;
    rel_cyc = cyc;
    after_reset = 1'b1;
  endtask

  initial begin
    logic [63:0] rnd;
    bit seen;
    int rises;
    reset_n = 1'b1;
    bus.osd_mask = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 check_reset_outputs("reset");
    release_reset();

    // Idle chain: nothing pressed.
    repeat (3) wait_frame();
    @(negedge clk);
    check("idle_zero", 64'(bus.joystick), 64'd0);

    // Serial bits 0 and 13 -> player 0 bit 0, player 1 bit 1.
    next_pat = '0;
    next_pat[0] = 1'b1;
    next_pat[13] = 1'b1;
    repeat (3) wait_frame();
    @(negedge clk);
    check("bits_0_13", 64'(bus.joystick), 64'h0000_0000_0002_0001);

    // Mask through capture, then unmask: latest frame appears immediately.
    @(posedge clk); #3;
    bus.osd_mask = 1'b1;
    next_pat = '0;
    next_pat[23] = 1'b1;
    repeat (3) wait_frame();
    @(negedge clk);
    check("masked_zero", 64'(bus.joystick), 64'd0);
    @(posedge clk); #3;
    bus.osd_mask = 1'b0;
    #1 check("unmask_bit27", 64'(bus.joystick), 64'h0000_0000_0800_0000);

    // One-frame glitch on bit 5, then a stable two-frame press.
    next_pat = '0;
    repeat (3) wait_frame();
    next_pat = 24'h000020;
    wait_frame();
    next_pat = '0;
    @(negedge clk);
`ifdef JOY_SERIAL_DEBOUNCE_EN
    check("glitch_bit5", 64'(bus.joystick[5]), 64'd0);
`else
    check("glitch_bit5", 64'(bus.joystick[5]), 64'd1);
`endif
    wait_frame();
    next_pat = 24'h000020;
    wait_frame();
    @(negedge clk);
`ifdef JOY_SERIAL_DEBOUNCE_EN
    check("press_1st_bit5", 64'(bus.joystick[5]), 64'd0);
`else
    check("press_1st_bit5", 64'(bus.joystick[5]), 64'd1);
`endif
    wait_frame();
    @(negedge clk);
    check("press_2nd_bit5", 64'(bus.joystick[5]), 64'd1);

    // Random frames, some repeated so the accept path is exercised, random masking.
    for (int i = 0; i < 14; i++) begin
      wait_frame();
      if ($urandom_range(0, 1) == 1) begin
        rnd = {$urandom(), $urandom()};
        next_pat = rnd[TOTAL-1:0];
      end
      @(posedge clk); #3;
      bus.osd_mask = ($urandom_range(0, 3) == 0);
    end
    @(posedge clk); #3;
    bus.osd_mask = 1'b0;

    // Reset mid-SHIFT with a non-zero frame visible.
    next_pat = 24'hA5A5A5;
    repeat (3) wait_frame();
    seen = 1'b0;
    rises = 0;
    for (int n = 0; n < 2 * PERIOD; n++) begin
      @(posedge clk);
      if (bus.joy_clk) rises++;
      if (rises >= 20) begin seen = 1'b1; break; end
    end
    check("shift_reached", 64'(seen), 64'd1);
    #3;
    reset_n = 1'b0;
    m_latched = '0;
    m_prev = '0;
    exp_q.delete();
    #1 check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    release_reset();
    repeat (2) wait_frame();
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/joy_serial_reader.md
JOY_SERIAL_READER -- requirements
Module: joy_serial_reader

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of joystick slots in the serial chain (1..4).
REQ-002 Parameter BITS_PER_PLAYER, default 12, bits shifted per player (1..16).
REQ-003 Parameter CLK_DIV, default 8, clk_sys cycles per shift tick (3..255).
REQ-004 Parameter FRAME_GAP, default 1024, idle clk_sys cycles between frames (0..65535).
REQ-005 clk_sys  input  1  system clock; the block's only clock.
REQ-006 reset_n  input  1  reset; asynchronous assert, active-low.
REQ-007 joy_data  input  1  serial data from the external shift chain; asynchronous; active-low buttons.
REQ-008 osd_mask  input  1  high forces the joystick output to zero.
REQ-009 joy_clk  output  1  shift clock to the chain.
REQ-010 joy_load  output  1  parallel-load strobe to the chain, active-low.
REQ-011 joystick  output  NUM_PLAYERS*16  player p in bits [p*16+15:p*16]; bits at or above BITS_PER_PLAYER are zero; active-high.
REQ-012 frame_done  output  1  one-cycle pulse when a frame has been captured.

Function
REQ-013 joy_data SHALL pass through a 2-flop synchronizer before use.
REQ-014 A tick SHALL occur every CLK_DIV clk_sys cycles; the tick divider SHALL restart on entry to LOAD.
REQ-015 States SHALL be: GAP, LOAD, SHIFT, UPDATE; after reset the FSM SHALL enter LOAD.
REQ-016 LOAD: joy_load=0 and joy_clk=0 for 1 tick, then go to SHIFT.
REQ-017 SHIFT: each bit SHALL take 2 ticks: first tick joy_clk=0 with the synchronized joy_data sampled at its end; second tick joy_clk=1.
REQ-018 After the NUM_PLAYERS*BITS_PER_PLAYER-th bit, including its joy_clk high tick, the FSM SHALL go to UPDATE.
REQ-019 Bit ordering: the first sampled bit SHALL be player 0 bit 0, then ascending within a player, then the next player.
REQ-020 Captured bits SHALL be inverted, so a low line means pressed and reads 1.
REQ-021 UPDATE SHALL last 1 cycle, pulse frame_done, and latch the raw frame as specified under Configuration.
REQ-022 GAP SHALL last FRAME_GAP cycles; with FRAME_GAP=0 it goes straight to LOAD.
REQ-023 Frame period SHALL be CLK_DIV*(1+2*NUM_PLAYERS*BITS_PER_PLAYER)+1+FRAME_GAP clk_sys cycles.
REQ-024 The joystick output SHALL change only on the cycle after UPDATE. All players change together; no partial frame is ever visible.
REQ-025 osd_mask SHALL gate the output combinationally. Capture continues while it is high, so deasserting it shows the latest latched frame immediately.
REQ-026 joy_clk and joy_load SHALL be driven from registers, glitch-free.

Reset
REQ-027 While reset_n=0: joystick=0, frame_done=0, joy_clk=0, joy_load=1, debounce history=0, divider=0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame. The first frame_done after release SHALL follow a full LOAD+SHIFT.

Configuration
REQ-029 Macro JOY_SERIAL_DEBOUNCE_EN SHALL select the output update rule.
- Defined: at UPDATE the output SHALL update only if the raw frame equals the previous raw frame. The raw frame is always stored as the new previous frame. frame_done pulses regardless.
- Undefined: the output SHALL update every UPDATE, and no history register SHALL exist.

Verification
REQ-030 NUM_PLAYERS=2, BITS_PER_PLAYER=12, CLK_DIV=4, FRAME_GAP=16, model joy_data all high -> frame_done every 213 cycles; joystick=0.
REQ-031 Same parameters, model drives low on serial bits 0 and 13 -> joystick[0]=1, joystick[17]=1, all other bits 0.
REQ-032 Model drives low on bit 23 of 24; osd_mask=1 through one frame, then 0 -> joystick=0 while masked, then bit 27 set on the next cycle with no frame wait.
REQ-033 reset_n pulsed low mid-SHIFT -> outputs immediately 0/0/0/1; next frame_done at 213 cycles minus FRAME_GAP (197) after release; no partial data seen.
REQ-034 With JOY_SERIAL_DEBOUNCE_EN, a 1-frame glitch on bit 5 -> joystick unchanged. A stable 2-frame press -> bit 5 set after the 2nd frame_done. Without the macro, set after the 1st.
